// File: rtl/hd_corrector.sv
// hd_corrector: pipelined Hamming SEC decoder for {parity, data} codewords, latency 3,
// with saturating corrected/uncorrectable error counters.
module hd_corrector #(
    parameter int K = 8,
    parameter int CW = 16,
    localparam int M = K <= 1 ? 2 : K <= 4 ? 3 : K <= 11 ? 4 : K <= 26 ? 5 : K <= 57 ? 6 :
                       K <= 120 ? 7 : K <= 247 ? 8 : K <= 502 ? 9 : K <= 1013 ? 10 : 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cvld,
    input  logic [K+M-1:0]  cin,
    input  logic            cnt_clr,
    output logic            dvld,
    output logic [K-1:0]    dout,
    output logic            err_corr,
    output logic            err_uncorr,
    output logic [CW-1:0]   corr_cnt,
    output logic [CW-1:0]   uncorr_cnt
);
    localparam logic [M-1:0] NPOS = M'(K + M);

    // Hamming position of data bit i: the i-th non-power-of-two position
    function automatic logic [M-1:0] dpos(input int i);
        int n;
        n = 0;
        for (int q = 1; q <= K + M; q++)
            if ((q & (q - 1)) != 0) begin
                if (n == i) return M'(q);
                n++;
            end
        return '0;
    endfunction

    logic           v1, v2;
    logic [K+M-1:0] c1;
    logic [K-1:0]   d2, fix;
    logic [M-1:0]   syn_c, syn2;
    logic           corr_c, uncorr_c;

    always_comb begin
        syn_c = c1[K+M-1:K];
        for (int i = 0; i < K; i++)
            syn_c = syn_c ^ ({M{c1[i]}} & dpos(i));
    end

    always_comb begin
        fix = d2;
        for (int i = 0; i < K; i++)
            if (syn2 == dpos(i)) fix[i] = ~d2[i];
    end

    assign uncorr_c = syn2 > NPOS;
    assign corr_c   = syn2 != '0 && !uncorr_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1         <= 1'b0;
            c1         <= '0;
            v2         <= 1'b0;
            d2         <= '0;
            syn2       <= '0;
            dvld       <= 1'b0;
            dout       <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            v1         <= cvld;
            c1         <= cin;
            v2         <= v1;
            d2         <= c1[K-1:0];
            syn2       <= syn_c;
            dvld       <= v2;
            dout       <= v2 ? fix : dout;
            err_corr   <= v2 && corr_c;
            err_uncorr <= v2 && uncorr_c;
            // clear has priority over a same-cycle increment
            corr_cnt   <= cnt_clr ? '0 : (dvld && err_corr && corr_cnt != '1) ? corr_cnt + 1'b1 : corr_cnt;
            uncorr_cnt <= cnt_clr ? '0 : (dvld && err_uncorr && uncorr_cnt != '1) ? uncorr_cnt + 1'b1 : uncorr_cnt;
        end
    end
endmodule

// File: tb/tb_hd_corrector.sv
// tb_hd_corrector: directed vectors for hd_corrector (K=8) plus a CW=2 instance for saturation.
module tb_hd_corrector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cvld = 1'b0;
    logic [11:0] cin = '0;
    logic        cnt_clr = 1'b0;
    logic        dvld, err_corr, err_uncorr;
    logic [7:0]  dout;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic        s_dvld, s_err_corr, s_err_uncorr;
    logic [7:0]  s_dout;
    logic [1:0]  s_corr_cnt, s_uncorr_cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hd_corrector #(.K(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .cvld(cvld), .cin(cin), .cnt_clr(cnt_clr),
        .dvld(dvld), .dout(dout), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hd_corrector #(.K(8), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .cvld(cvld), .cin(cin), .cnt_clr(cnt_clr),
        .dvld(s_dvld), .dout(s_dout), .err_corr(s_err_corr), .err_uncorr(s_err_uncorr),
        .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // single beat: output visible three negedges after driving, counters one negedge later
    task automatic beat(input string tag, input logic [11:0] c, input logic [7:0] ed,
                        input logic ec, input logic eu, input logic [15:0] ecc, input logic [15:0] euc);
        @(negedge clk);
        cvld = 1'b1;
        cin = c;
        @(negedge clk);
        cvld = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " dvld"}, 32'(dvld), 32'd1);
        check({tag, " dout"}, 32'(dout), 32'(ed));
        check({tag, " err_corr"}, 32'(err_corr), 32'(ec));
        check({tag, " err_uncorr"}, 32'(err_uncorr), 32'(eu));
        @(negedge clk);
        check({tag, " dvld drop"}, 32'(dvld), 32'd0);
        check({tag, " flags idle"}, 32'({err_corr, err_uncorr}), 32'd0);
        check({tag, " dout hold"}, 32'(dout), 32'(ed));
        check({tag, " corr_cnt"}, 32'(corr_cnt), 32'(ecc));
        check({tag, " uncorr_cnt"}, 32'(uncorr_cnt), 32'(euc));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset dvld", 32'(dvld), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check("reset cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        rst = 1'b1;
        beat("clean", 12'h3A5, 8'hA5, 1'b0, 1'b0, 16'd0, 16'd0);
        beat("data_err", 12'h3A1, 8'hA5, 1'b1, 1'b0, 16'd1, 16'd0);
        beat("par_err", 12'h2A5, 8'hA5, 1'b1, 1'b0, 16'd2, 16'd0);
        beat("uncorr", 12'h225, 8'h25, 1'b0, 1'b1, 16'd2, 16'd1);
        check("sat pre", 32'(s_corr_cnt), 32'd2);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr corr", 32'(corr_cnt), 32'd0);
        check("clr uncorr", 32'(uncorr_cnt), 32'd0);
        // streaming: beat t driven at negedge t, observed at negedge t+3
        for (int t = 0; t < 14; t++) begin
            if (t >= 3 && t < 13) begin
                check($sformatf("stream dvld %0d", t - 3), 32'(dvld), 32'd1);
                check($sformatf("stream dout %0d", t - 3), 32'(dout), 32'hA5);
                check($sformatf("stream corr %0d", t - 3), 32'(err_corr), 32'((t - 3) % 2));
            end
            cvld = t < 10;
            cin = (t % 2) ? 12'h3A1 : 12'h3A5;
            @(negedge clk);
        end
        check("stream corr_cnt", 32'(corr_cnt), 32'd5);
        check("sat corr_cnt", 32'(s_corr_cnt), 32'd3);
        check("stream dvld end", 32'(dvld), 32'd0);
        @(negedge clk);
        cvld = 1'b1;
        cin = 12'h3A1;
        @(negedge clk);
        cvld = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_vs_inc dvld", 32'(dvld & err_corr), 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_vs_inc cnt", 32'(corr_cnt), 32'd0);
        check("clr_vs_inc sat", 32'(s_corr_cnt), 32'd0);
        beat("pre_rst", 12'h3A1, 8'hA5, 1'b1, 1'b0, 16'd1, 16'd0);
        @(negedge clk);
        cvld = 1'b1;
        cin = 12'h2A5;
        @(negedge clk);
        cin = 12'h225;
        @(negedge clk);
        cvld = 1'b0;
        rst = 1'b0;
        #1;
        check("rst dvld", 32'(dvld), 32'd0);
        check("rst dout", 32'(dout), 32'd0);
        check("rst corr_cnt", 32'(corr_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check($sformatf("post_rst dvld %0d", t), 32'(dvld), 32'd0);
            check($sformatf("post_rst out %0d", t), 32'({dout, err_corr, err_uncorr, corr_cnt, uncorr_cnt}), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hd_corrector.md
Name: hd_corrector

Overview:
- Hamming single-error-correcting decoder; sits directly downstream of the Hamming encoder (he_top) and consumes its codewords.
- Input codeword layout is {parity[M-1:0], data[K-1:0]}.
- Computes the syndrome, corrects any single-bit error, flags uncorrectable syndromes and keeps saturating error statistics.
- Fully pipelined: accepts one codeword per cycle, fixed latency 3.

Parameters:
- K, 8, data width in bits.
- M, derived localparam (not overridable): 2 for K=1, 3 for K<=4, 4 for K<=11, 5 for K<=26, 6 for K<=57, 7 for K<=120, 8 for K<=247, 9 for K<=502, 10 for K<=1013, else 11.
- CW, 16, width of each error counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cvld  input  1  codeword valid.
- cin  input  K+M  codeword {parity, data}.
- cnt_clr  input  1  synchronous clear of both counters.
- dvld  output  1  decoded data valid.
- dout  output  K  corrected data.
- err_corr  output  1  single error corrected on this beat (data bit or parity bit); qualified by dvld.
- err_uncorr  output  1  syndrome points outside the codeword; qualified by dvld.
- corr_cnt  output  CW  saturating count of err_corr beats.
- uncorr_cnt  output  CW  saturating count of err_uncorr beats.

Behaviour:
- Reset: clk is a single clock; rst is asynchronous and active-low. While rst=0, all pipeline registers, valids, dout, flags and counters are 0.
- Reset mid-stream: in-flight beats are discarded and no dvld is produced for them.
- Position map:
  - Hamming positions run 1..K+M.
  - Parity bit j sits at position 2^j.
  - Data bit i sits at the i-th non-power-of-two position in ascending order. For K=8 that is positions 3,5,6,7,9,10,11,12.
- Parity rule:
  - p[j] is the XOR of the data bits whose position has bit j set.
  - syn[j] = cin parity[j] XOR recomputed p[j].
- Pipeline:
  - S1 registers cvld/cin.
  - S2 registers the syndrome plus the data and valid.
  - S3 registers dout, flags and dvld.
  - Latency: cvld at edge n gives dvld at edge n+3. No back-pressure; every valid beat emerges.
- Decode rule on the S2->S3 transfer:
  - syn=0: dout = data; err_corr=0; err_uncorr=0.
  - syn a power of two: parity bit error; dout = data unmodified; err_corr=1.
  - syn equal to a data position: dout = data with that bit inverted; err_corr=1.
  - syn > K+M: dout = raw data; err_uncorr=1; err_corr=0.
  - err_corr and err_uncorr are never both 1.
  - When dvld=0, both flags are 0 and dout holds its last value.
- Counters:
  - Increment by 1 on each dvld beat carrying the corresponding flag.
  - Saturate at 2^CW-1 with no wrap.
  - cnt_clr=1 sets both counters to 0 next edge. Clear wins over a simultaneous increment.
- Double errors whose syndrome lands inside 1..K+M are miscorrected. This is an accepted limitation of SEC without an overall parity bit.

Test Plan (K=8, M=4, CW=16):
- Clean word: cin=12'h3A5, cvld one cycle -> 3 cycles later dvld=1, dout=8'hA5, err_corr=0, err_uncorr=0; counters unchanged.
- Data error: cin=12'h3A1 (bit 2 flipped, syndrome 6) -> dout=8'hA5, err_corr=1, corr_cnt=1.
- Parity error: cin=12'h2A5 (p0 flipped, syndrome 1) -> dout=8'hA5, err_corr=1, corr_cnt increments.
- Uncorrectable: cin=12'h225 (p0 and d7 flipped, syndrome 13) -> dout=8'h25, err_uncorr=1, err_corr=0, uncorr_cnt=1.
- Streaming: back-to-back cvld for 10 cycles with alternating 12'h3A5/12'h3A1 -> 10 consecutive dvld, all dout=8'hA5, corr_cnt=5. Then cnt_clr asserted in the same cycle as a corrected beat -> corr_cnt=0.
- Saturation and reset:
  - Preload via CW=2 build: 5 corrected beats -> corr_cnt=3.
  - Assert rst low with 2 beats in flight -> dvld stays 0 and all outputs read 0 after release.
